// File: rtl/arbitro_vc_d_pkg.sv
// Shared defaults and types for the VC-to-destination arbiter.
package arbitro_vc_d_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 6;
  localparam int unsigned DEF_CNT_WIDTH  = 8;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

endpackage

// File: rtl/arbitro_vc_d_contador_destino.sv
// Wrapping per-destination word counter with increment enable.
module arbitro_vc_d_contador_destino #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + W'(1);
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/arbitro_vc_d.sv
// Arbiter moving VC0/VC1 head words into destination FIFOs D0/D1.
// Define ARB_RR_EN for round-robin; otherwise VC0 has fixed priority.
module arbitro_vc_d
  import arbitro_vc_d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic                  VC0_empty,
  input  logic                  VC1_empty,
  input  logic [DATA_WIDTH-1:0] VC0_data,
  input  logic [DATA_WIDTH-1:0] VC1_data,
  input  logic                  D0_almost_full,
  input  logic                  D1_almost_full,
  output logic                  VC0_pop,
  output logic                  VC1_pop,
  output logic                  D0_push,
  output logic                  D1_push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  D0_count,
  output logic [CNT_WIDTH-1:0]  D1_count,
  output logic                  arb_idle
);

  localparam int unsigned DEST_BIT = DATA_WIDTH - 1;

  logic                  dst0, dst1;
  logic                  req0, req1;
  logic                  elig0, elig1;
  logic                  gnt0, gnt1, gnt_any, gnt_dst;
  logic [DATA_WIDTH-1:0] gnt_word;

  logic                  push0_q, push0_d;
  logic                  push1_q, push1_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign dst0 = VC0_data[DEST_BIT];
  assign dst1 = VC1_data[DEST_BIT];

  // A request exists whenever a head word has room downstream; grants need active_in too
  assign req0  = ~VC0_empty & ~(dst0 ? D1_almost_full : D0_almost_full);
  assign req1  = ~VC1_empty & ~(dst1 ? D1_almost_full : D0_almost_full);
  assign elig0 = req0 & active_in & ~reset;
  assign elig1 = req1 & active_in & ~reset;

`ifdef ARB_RR_EN
  vc_e ptr_q, ptr_d;

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    ptr_d = ptr_q;
    if (elig0 && (!elig1 || ptr_q == VC0)) begin
      gnt0  = 1'b1;
      ptr_d = VC1;
    end else if (elig1) begin
      gnt1  = 1'b1;
      ptr_d = VC0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= VC0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt0 = elig0;
    gnt1 = elig1 & ~elig0;
  end
`endif

  assign gnt_any  = gnt0 | gnt1;
  assign gnt_word = gnt0 ? VC0_data : VC1_data;
  assign gnt_dst  = gnt_word[DEST_BIT];

  always_comb begin
    push0_d = gnt_any & ~gnt_dst;
    push1_d = gnt_any & gnt_dst;
    data_d  = data_q;
    if (gnt_any) data_d = gnt_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      data_q  <= '0;
    end else begin
      push0_q <= push0_d;
      push1_q <= push1_d;
      data_q  <= data_d;
    end
  end

  arbitro_vc_d_contador_destino #(.W(CNT_WIDTH)) u_cnt_d0 (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (push0_d),
    .count_o (D0_count)
  );

  arbitro_vc_d_contador_destino #(.W(CNT_WIDTH)) u_cnt_d1 (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (push1_d),
    .count_o (D1_count)
  );

  assign VC0_pop  = gnt0;
  assign VC1_pop  = gnt1;
  assign D0_push  = push0_q;
  assign D1_push  = push1_q;
  assign data_out = data_q;
  assign arb_idle = ~req0 & ~req1 & ~push0_q & ~push1_q;

endmodule

// File: tb/tb_arbitro_vc_d.sv
// Scoreboard bench for arbitro_vc_d: VC FIFOs modelled as queues, grants predicted per cycle.
module tb_arbitro_vc_d;

  localparam int unsigned DW = 6;
  localparam int unsigned CW = 8;

  logic          clk, reset, active_in;
  logic          VC0_empty, VC1_empty;
  logic [DW-1:0] VC0_data, VC1_data;
  logic          D0_almost_full, D1_almost_full;
  logic          VC0_pop, VC1_pop, D0_push, D1_push, arb_idle;
  logic [DW-1:0] data_out;
  logic [CW-1:0] D0_count, D1_count;

  arbitro_vc_d dut (
    .clk            (clk),
    .reset          (reset),
    .active_in      (active_in),
    .VC0_empty      (VC0_empty),
    .VC1_empty      (VC1_empty),
    .VC0_data       (VC0_data),
    .VC1_data       (VC1_data),
    .D0_almost_full (D0_almost_full),
    .D1_almost_full (D1_almost_full),
    .VC0_pop        (VC0_pop),
    .VC1_pop        (VC1_pop),
    .D0_push        (D0_push),
    .D1_push        (D1_push),
    .data_out       (data_out),
    .D0_count       (D0_count),
    .D1_count       (D1_count),
    .arb_idle       (arb_idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          dest;
    logic [DW-1:0] data;
  } exp_t;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  exp_t          sb[$];

  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] m_cnt0, m_cnt1;
  logic [DW-1:0] m_last;
  logic          m_ptr, m_p0, m_p1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    VC0_empty = (q0.size() == 0);
    VC1_empty = (q1.size() == 0);
    VC0_data  = (q0.size() != 0) ? q0[0] : '0;
    VC1_data  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt0 = '0;
    m_cnt1 = '0;
    m_last = '0;
    m_ptr  = 1'b0;
    m_p0   = 1'b0;
    m_p1   = 1'b0;
  endtask

  // One cycle: predict grant, check pops/idle, then check the registered result
  task automatic step(input string tag);
    logic d0, d1, r0, r1, e0, e1, g0, g1;
    exp_t ex;
    drive_inputs();
    #1;
    d0 = (q0.size() != 0) ? q0[0][DW-1] : 1'b0;
    d1 = (q1.size() != 0) ? q1[0][DW-1] : 1'b0;
    r0 = (q0.size() != 0) && !(d0 ? D1_almost_full : D0_almost_full);
    r1 = (q1.size() != 0) && !(d1 ? D1_almost_full : D0_almost_full);
    e0 = r0 && active_in;
    e1 = r1 && active_in;
`ifdef ARB_RR_EN
    g0 = e0 && (!e1 || m_ptr == 1'b0);
    g1 = e1 && !g0;
`else
    g0 = e0;
    g1 = e1 && !e0;
`endif
    check_eq({tag, ".pop0"}, 32'(VC0_pop), 32'(g0));
    check_eq({tag, ".pop1"}, 32'(VC1_pop), 32'(g1));
    check_eq({tag, ".idle"}, 32'(arb_idle), 32'(!r0 && !r1 && !m_p0 && !m_p1));
    if (g0) sb.push_back('{dest: d0, data: q0[0]});
    if (g1) sb.push_back('{dest: d1, data: q1[0]});
    @(posedge clk);
    #1;
    if (g0) begin void'(q0.pop_front()); m_ptr = 1'b1; end
    if (g1) begin void'(q1.pop_front()); m_ptr = 1'b0; end
    if (sb.size() != 0) begin
      ex     = sb.pop_front();
      m_p0   = !ex.dest;
      m_p1   = ex.dest;
      m_last = ex.data;
      if (ex.dest) m_cnt1 = m_cnt1 + CW'(1);
      else         m_cnt0 = m_cnt0 + CW'(1);
    end else begin
      m_p0 = 1'b0;
      m_p1 = 1'b0;
    end
    check_eq({tag, ".push0"}, 32'(D0_push), 32'(m_p0));
    check_eq({tag, ".push1"}, 32'(D1_push), 32'(m_p1));
    check_eq({tag, ".data"}, 32'(data_out), 32'(m_last));
    check_eq({tag, ".cnt0"}, 32'(D0_count), 32'(m_cnt0));
    check_eq({tag, ".cnt1"}, 32'(D1_count), 32'(m_cnt1));
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    drive_inputs();
    #1;
    check_eq({tag, ".push0"}, 32'(D0_push), 32'd0);
    check_eq({tag, ".push1"}, 32'(D1_push), 32'd0);
    check_eq({tag, ".data"}, 32'(data_out), 32'd0);
    check_eq({tag, ".cnt0"}, 32'(D0_count), 32'd0);
    check_eq({tag, ".cnt1"}, 32'(D1_count), 32'd0);
    check_eq({tag, ".pop0"}, 32'(VC0_pop), 32'd0);
    check_eq({tag, ".pop1"}, 32'(VC1_pop), 32'd0);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    clk            = 1'b0;
    reset          = 1'b1;
    active_in      = 1'b1;
    D0_almost_full = 1'b0;
    D1_almost_full = 1'b0;
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset values, and no pop while reset is high even with data queued
    q0.push_back(6'b0_00101);
    async_reset("rst0");

    // Single word VC0 -> D0
    step("single");
    check_eq("single.cnt0_is1", 32'(D0_count), 32'd1);
    check_eq("single.data_val", 32'(data_out), 32'h05);
    step("single_after");

    // VC0 blocked by D0 almost full, VC1 proceeds
    q0.push_back(6'b0_00111);
    q1.push_back(6'b1_00011);
    D0_almost_full = 1'b1;
    step("bp_a");
    check_eq("bp.d1_push", 32'(D1_push), 32'd1);
    check_eq("bp.vc0_held", 32'(q0.size()), 32'd1);
    step("bp_b");
    D0_almost_full = 1'b0;
    step("bp_c");
    step("bp_d");

    // Four words per VC, all destinations free
    for (int i = 0; i < 4; i++) begin
      q0.push_back(DW'({i[0], 2'b00, i[2:0]}));
      q1.push_back(DW'({~i[0], 2'b11, i[2:0]}));
    end
    for (int i = 0; i < 8; i++) step($sformatf("burst%0d", i));
    check_eq("burst.drained", 32'(q0.size() + q1.size()), 32'd0);
    step("burst_tail");

    // active_in low holds traffic without reporting idle
    active_in = 1'b0;
    q0.push_back(6'b1_01010);
    q1.push_back(6'b0_10101);
    step("inact_a");
    step("inact_b");
    check_eq("inact.not_idle", 32'(arb_idle), 32'd0);
    active_in = 1'b1;
    step("react_a");
    step("react_b");
    step("react_c");

    // Random traffic, backpressure and enable
    for (int i = 0; i < 300; i++) begin
      if (q0.size() < 6 && $urandom_range(0, 1) == 0) q0.push_back(DW'($urandom));
      if (q1.size() < 6 && $urandom_range(0, 1) == 0) q1.push_back(DW'($urandom));
      D0_almost_full = ($urandom_range(0, 3) == 0);
      D1_almost_full = ($urandom_range(0, 3) == 0);
      active_in      = ($urandom_range(0, 7) != 0);
      step($sformatf("rnd%0d", i));
    end

    // Async reset in the middle of a push
    D0_almost_full = 1'b0;
    D1_almost_full = 1'b0;
    active_in      = 1'b1;
    q0.delete();
    q1.delete();
    q0.push_back(6'b0_11100);
    step("midrst_grant");
    check_eq("midrst.push_seen", 32'(D0_push), 32'd1);
    async_reset("midrst");
    step("midrst_after");

    // 256 words to D1 wrap its counter
    for (int i = 0; i < 256; i++) q1.push_back(DW'({1'b1, i[4:0]}));
    for (int i = 0; i < 256; i++) step($sformatf("wrap%0d", i));
    check_eq("wrap.d1_zero", 32'(D1_count), 32'd0);
    check_eq("wrap.last_push", 32'(D1_push), 32'd1);
    step("wrap_tail");
    check_eq("wrap.idle", 32'(arb_idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
